// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED pattern engine: direction encoding and
// prescaler sizing derived from clock frequency and step rate.
package led_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Clock cycles per pattern step, never less than one.
  function automatic int tick_div(input int clk_freq, input int steps);
    int q;
    if (steps <= 0) begin
      q = 1;
    end else begin
      q = clk_freq / steps;
    end
    return (q < 1) ? 1 : q;
  endfunction

  // Prescaler width; at least one bit so a divide-by-one build still has a register.
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle,
// which is the edge on which the owner should step its pattern.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int CLK_FREQ      = 25_000_000,
  parameter int STEPS_PER_SEC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, STEPS_PER_SEC);
  localparam int CW       = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == LAST);
  assign tick    = en && !clr && at_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (at_last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pattern_shifter.sv
// LED pattern engine: rotates a WIDTH-bit pattern once per prescaler tick, with runtime
// direction, pause and load. Bounce mode is built only when LED_PATTERN_BOUNCE_EN is defined.
module led_pattern_shifter
  import led_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               CLK_FREQ      = 25_000_000,
  parameter int               STEPS_PER_SEC = 4,
  parameter logic [WIDTH-1:0] INIT_PATTERN  = WIDTH'('h1F)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             bounce,
  input  logic             load,
  input  logic [WIDTH-1:0] load_pattern,
  output logic [WIDTH-1:0] leds,
  output logic             step_tick
);

  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
    return {v[0], v[WIDTH-1:1]};
  endfunction

  logic tick;
  logic step;
  logic step_dir;

  led_tick_gen #(
    .CLK_FREQ      (CLK_FREQ),
    .STEPS_PER_SEC (STEPS_PER_SEC)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (load),
    .tick  (tick)
  );

  // A load on the same edge pre-empts the step and restarts the prescaler.
  assign step = tick && !load;

`ifdef LED_PATTERN_BOUNCE_EN
  logic bounce_dir;
  logic eff_dir;
  logic at_end;

  always_comb begin
    eff_dir  = bounce ? bounce_dir : dir;
    at_end   = (eff_dir == DIR_LEFT) ? leds[WIDTH-1] : leds[0];
    step_dir = (bounce && at_end) ? ~eff_dir : eff_dir;
  end

  // Tracks dir while bounce is off so enabling bounce starts in the user's direction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bounce_dir <= DIR_LEFT;
    end else if (!bounce) begin
      bounce_dir <= dir;
    end else if (step) begin
      bounce_dir <= step_dir;
    end
  end
`else
  // bounce has no effect in this build; the masked term keeps the port referenced.
  assign step_dir = dir ^ (bounce & 1'b0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      leds      <= INIT_PATTERN;
      step_tick <= 1'b0;
    end else begin
      step_tick <= step;
      if (load) begin
        leds <= load_pattern;
      end else if (step) begin
        leds <= (step_dir == DIR_RIGHT) ? rot_right(leds) : rot_left(leds);
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_shifter.sv
// Scoreboard bench for led_pattern_shifter at TICK_DIV=2, WIDTH=8, INIT_PATTERN=8'h1F.
module tb_led_pattern_shifter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       bounce = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_pattern = 8'h00;
  logic [7:0] leds;
  logic       step_tick;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];

  led_pattern_shifter #(
    .WIDTH         (8),
    .CLK_FREQ      (8),
    .STEPS_PER_SEC (4),
    .INIT_PATTERN  (8'h1F)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .dir          (dir),
    .bounce       (bounce),
    .load         (load),
    .load_pattern (load_pattern),
    .leds         (leds),
    .step_tick    (step_tick)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every step_tick pulse must match the next queued pattern.
  always @(negedge clk) begin
    if (rst_n && step_tick === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_step: got leds %h, no step expected", leds);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (leds !== e) begin
          mismatched++;
          $display("FAIL step_leds: got %h expected %h", leds, e);
        end
      end
    end
  end

  // Advance n posedges, then settle mid-cycle after the monitor has sampled.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic d, input logic b);
    rst_n = 1'b0;
    en = 1'b1;
    dir = d;
    bounce = b;
    load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_drained(input string name);
    check8(name, 8'(exp_q.size()), 8'd0);
    exp_q.delete();
  endtask

  initial begin
    // 1: rotate left from reset
    do_reset(1'b0, 1'b0);
    check8("reset_leds", leds, 8'h1F);
    check8("reset_tick", {7'd0, step_tick}, 8'h00);
    push(8'h3E); push(8'h7C); push(8'hF8); push(8'hF1);
    cycles(8);
    check_drained("left_steps");

    // 2: rotate right from reset
    do_reset(1'b1, 1'b0);
    push(8'h8F); push(8'hC7); push(8'hE3);
    cycles(6);
    check_drained("right_steps");

    // 3: pause with one prescaler count still pending
    do_reset(1'b0, 1'b0);
    push(8'h3E);
    cycles(3);
    check_drained("pre_pause");
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      check8("pause_hold", leds, 8'h3E);
    end
    push(8'h7C);
    en = 1'b1;
    cycles(1);
    check_drained("resume_step");

    // 4: load one cycle before a step pre-empts it
    do_reset(1'b0, 1'b0);
    push(8'h3E);
    cycles(3);
    check_drained("pre_load");
    load = 1'b1;
    load_pattern = 8'h81;
    cycles(1);
    load = 1'b0;
    check8("load_leds", leds, 8'h81);
    check8("load_no_tick", {7'd0, step_tick}, 8'h00);
    push(8'h03);
    cycles(1);
    check8("after_load_wait", leds, 8'h81);
    cycles(1);
    check_drained("after_load_step");
    // load accepted while paused
    en = 1'b0;
    load = 1'b1;
    load_pattern = 8'h5A;
    cycles(1);
    load = 1'b0;
    check8("load_paused", leds, 8'h5A);
    cycles(3);
    check8("paused_after_load", leds, 8'h5A);
    en = 1'b1;

    // 5: bounce mode
    do_reset(1'b0, 1'b1);
`ifdef LED_PATTERN_BOUNCE_EN
    push(8'h3E); push(8'h7C); push(8'hF8); push(8'h7C);
    push(8'h3E); push(8'h1F); push(8'h3E); push(8'h7C);
`else
    push(8'h3E); push(8'h7C); push(8'hF8); push(8'hF1);
    push(8'hE3); push(8'hC7); push(8'h8F); push(8'h1F);
`endif
    cycles(16);
    check_drained("bounce_steps");
    bounce = 1'b0;

    // 6: reset mid-run at 7C
    do_reset(1'b0, 1'b0);
    push(8'h3E); push(8'h7C);
    cycles(5);
    check_drained("pre_midreset");
    rst_n = 1'b0;
    cycles(1);
    check8("midreset_leds", leds, 8'h1F);
    check8("midreset_tick", {7'd0, step_tick}, 8'h00);
    rst_n = 1'b1;
    push(8'h3E);
    cycles(1);
    check8("restart_wait", leds, 8'h1F);
    cycles(1);
    check_drained("restart_step");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
